// File: rtl/mmu_l1tlb_sfence_if.sv
`default_nettype none
// ============================================================================
// Module   : mmu_l1tlb_sfence_if
// Brief    : Fence request handshake plus L1 TLB tag-read / invalidate bus
//            between the MMU control unit, the SFENCE.VMA engine and the
//            L1 TLB arrays.
// Revision : 1.0  initial release
// ============================================================================
interface mmu_l1tlb_sfence_if;
    // Fence request from the MMU control unit
    logic        i_sfence_valid;
    logic        o_sfence_ready;
    logic        i_sfence_vaddr_valid;
    logic [19:0] i_sfence_vpn_20;
    logic        i_sfence_asid_valid;
    logic [8:0]  i_sfence_asid_9;

    // Tag read port into the TLB arrays (data returns one cycle later)
    logic        o_rd_en;
    logic [1:0]  o_rd_sel_2;
    logic [4:0]  o_rd_index_5;
    logic        i_rd_valid;
    logic        i_rd_global;
    logic [8:0]  i_rd_asid_9;
    logic [19:0] i_rd_vpn_20;

    // Invalidate controls and status
    logic [1:0]  o_inv_en_2;
    logic [4:0]  o_inv_index_5;
    logic        o_flush_all;
    logic        o_busy;
    logic        o_done;

    // The fence engine itself
    modport slave (
        input  i_sfence_valid,
        output o_sfence_ready,
        input  i_sfence_vaddr_valid,
        input  i_sfence_vpn_20,
        input  i_sfence_asid_valid,
        input  i_sfence_asid_9,
        output o_rd_en,
        output o_rd_sel_2,
        output o_rd_index_5,
        input  i_rd_valid,
        input  i_rd_global,
        input  i_rd_asid_9,
        input  i_rd_vpn_20,
        output o_inv_en_2,
        output o_inv_index_5,
        output o_flush_all,
        output o_busy,
        output o_done
    );

    // Control unit / TLB side driving the engine
    modport master (
        output i_sfence_valid,
        input  o_sfence_ready,
        output i_sfence_vaddr_valid,
        output i_sfence_vpn_20,
        output i_sfence_asid_valid,
        output i_sfence_asid_9,
        input  o_rd_en,
        input  o_rd_sel_2,
        input  o_rd_index_5,
        output i_rd_valid,
        output i_rd_global,
        output i_rd_asid_9,
        output i_rd_vpn_20,
        input  o_inv_en_2,
        input  o_inv_index_5,
        input  o_flush_all,
        input  o_busy,
        input  o_done
    );
endinterface
`default_nettype wire

// File: rtl/mmu_l1tlb_sfence.sv
`default_nettype none
// ============================================================================
// Module   : mmu_l1tlb_sfence
// Brief    : SFENCE.VMA invalidation engine for the Sv32 L1 TLB
//            (32 normal 4 KiB entries + 4 super 4 MiB entries). A global
//            fence clears everything in one cycle; a filtered fence scans all
//            36 entries through the tag read port and invalidates matches.
// Revision : 1.0  initial release
// ============================================================================
module mmu_l1tlb_sfence (
    input  wire               clk,
    input  wire               rst,
    mmu_l1tlb_sfence_if.slave bus
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_FLUSH_ALL = 3'd1;
    localparam logic [2:0] c_SCAN      = 3'd2;
    localparam logic [2:0] c_DRAIN     = 3'd3;
    localparam logic [2:0] c_DONE      = 3'd4;

    // Scan order: normal entries 0..31, then super entries 0..3 as 32..35
    localparam logic [5:0] c_LAST_ENTRY = 6'd35;
    localparam logic [1:0] c_SEL_NORMAL = 2'b01;
    localparam logic [1:0] c_SEL_SUPER  = 2'b10;

    logic [2:0]  r_state;
    logic [5:0]  r_cnt;

    logic        r_vaddr_valid;
    logic [19:0] r_vpn;
    logic        r_asid_valid;
    logic [8:0]  r_asid;

    // Tag of the read issued last cycle; identifies the data returning now
    logic        r_p_en;
    logic [1:0]  r_p_sel;
    logic [4:0]  r_p_index;

    logic        w_accept;
    logic        w_global_fence;
    logic        w_rd_en;
    logic [1:0]  w_rd_sel;
    logic [4:0]  w_rd_index;
    logic        w_vpn_ok;
    logic        w_asid_ok;
    logic        w_match;

    assign w_accept       = bus.i_sfence_valid && (r_state == c_IDLE);
    assign w_global_fence = !bus.i_sfence_vaddr_valid && !bus.i_sfence_asid_valid;

    // cnt[5] set means the super array; its index lives in cnt[1:0]
    assign w_rd_en    = (r_state == c_SCAN);
    assign w_rd_sel   = w_rd_en ? (r_cnt[5] ? c_SEL_SUPER : c_SEL_NORMAL) : 2'b00;
    assign w_rd_index = w_rd_en ? (r_cnt[5] ? {3'b000, r_cnt[1:0]} : r_cnt[4:0]) : 5'd0;

    // Super pages only translate VPN[19:10]; global entries ignore ASID filters
    assign w_vpn_ok  = !r_vaddr_valid ||
                       (r_p_sel[1] ? (bus.i_rd_vpn_20[19:10] == r_vpn[19:10])
                                   : (bus.i_rd_vpn_20 == r_vpn));
    assign w_asid_ok = !r_asid_valid || (!bus.i_rd_global && (bus.i_rd_asid_9 == r_asid));
    assign w_match   = r_p_en && bus.i_rd_valid && w_vpn_ok && w_asid_ok;

    assign bus.o_sfence_ready = (r_state == c_IDLE);
    assign bus.o_busy         = (r_state != c_IDLE);
    assign bus.o_flush_all    = (r_state == c_FLUSH_ALL);
    assign bus.o_done         = (r_state == c_DONE);
    assign bus.o_rd_en        = w_rd_en;
    assign bus.o_rd_sel_2     = w_rd_sel;
    assign bus.o_rd_index_5   = w_rd_index;
    assign bus.o_inv_en_2     = w_match ? r_p_sel : 2'b00;
    assign bus.o_inv_index_5  = w_match ? r_p_index : 5'd0;

    // Fence sequencing and scan counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= 6'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= 6'd0;
                        r_state <= w_global_fence ? c_FLUSH_ALL : c_SCAN;
                    end
                end
                c_FLUSH_ALL: r_state <= c_DONE;
                c_SCAN: begin
                    if (r_cnt == c_LAST_ENTRY) begin
                        r_cnt   <= 6'd0;
                        r_state <= c_DRAIN;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                c_DRAIN: r_state <= c_DONE;
                c_DONE:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Capture the filter operands when a request is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vaddr_valid <= 1'b0;
            r_vpn         <= 20'd0;
            r_asid_valid  <= 1'b0;
            r_asid        <= 9'd0;
        end else if (w_accept) begin
            r_vaddr_valid <= bus.i_sfence_vaddr_valid;
            r_vpn         <= bus.i_sfence_vpn_20;
            r_asid_valid  <= bus.i_sfence_asid_valid;
            r_asid        <= bus.i_sfence_asid_9;
        end
    end

    // Delay the read tag by one cycle to line up with the returned tag data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p_en    <= 1'b0;
            r_p_sel   <= 2'b00;
            r_p_index <= 5'd0;
        end else begin
            r_p_en    <= w_rd_en;
            r_p_sel   <= w_rd_sel;
            r_p_index <= w_rd_index;
        end
    end

endmodule
`default_nettype wire
